ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter UUID, default 0, instance identifier XORed into child UUIDs.
REQ-002 Parameter NAME, default "", instance label.
REQ-003 Parameter WORD_COUNT, default 4096, RAM depth in 32-bit words; address width 12.
REQ-004 Parameter STARVE_LIMIT, default 4, number of consecutive denied cycles after which B gets priority; range 1..15.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 a_req  in  1  requester A (CPU datapath) access request.
REQ-009 a_we  in  1  A write when 1, read when 0.
REQ-010 a_lock  in  1  A requests exclusive access after this access.
REQ-011 a_addr  in  12  A word address.
REQ-012 a_wdata  in  32  A write data.
REQ-013 a_gnt  out  1  A access performed this cycle.
REQ-014 a_rvalid  out  1  A read data valid.
REQ-015 a_rdata  out  32  A read data.
REQ-016 b_req, b_we, b_addr[12], b_wdata[32]  in  B (console/DMA) request fields, same meaning as A.
REQ-017 b_gnt, b_rvalid, b_rdata[32]  out  B response fields, same meaning as A.
REQ-018 ram_load  out  1  RAM read strobe.
REQ-019 ram_save  out  1  RAM write strobe.
REQ-020 ram_address  out  32  RAM word address, zero-extended from 12 bits.
REQ-021 ram_in  out  32  RAM write data.
REQ-022 ram_out  in  32  RAM read data, valid the cycle after ram_load.
REQ-023 locked  out  1  exclusive-lock status.

Function
REQ-024 Grant is combinational in the request cycle; at most one of a_gnt, b_gnt is high per cycle.
REQ-025 Default priority: A wins when both request.
REQ-026 starve counter (4 bits) increments, saturating at STARVE_LIMIT, each cycle b_req=1 and b_gnt=0; clears when b_gnt=1 or b_req=0.
REQ-027 When starve == STARVE_LIMIT and locked=0, B wins over A.
REQ-028 While locked=1, b_gnt stays 0 and starve holds its value at saturation.
REQ-029 locked sets on a granted A access with a_lock=1; clears on a granted A access with a_lock=0; both effective next cycle.
REQ-030 Granted requester drives ram_address, ram_in; ram_save = gnt & we; ram_load = gnt & ~we; all zero when no grant.
REQ-031 FSM states IDLE, RD_A, RD_B track the outstanding read: granted read by A moves to RD_A, by B to RD_B, otherwise IDLE; transitions every cycle.
REQ-032 In RD_A: a_rvalid=1, a_rdata=ram_out; in RD_B: b_rvalid=1, b_rdata=ram_out; rdata is 0 when the matching rvalid is 0.
REQ-033 Read latency fixed at 1 cycle; back-to-back reads from either requester are accepted every cycle without bubbles.
REQ-034 Write has no response; write data is committed in the grant cycle.
REQ-035 A write and a read to the same address in consecutive grant cycles return the written value.
REQ-036 Denied requesters hold their request; the arbiter does not queue requests.

Reset
REQ-037 On rst: FSM to IDLE, starve=0, locked=0; all outputs 0 in the cycle after rst, ram strobes 0 during rst.
REQ-038 A read granted in the cycle before rst produces no rvalid.

Verification
REQ-039 Both request every cycle, STARVE_LIMIT=4 -> a_gnt cycles 0-3, b_gnt cycle 4, a_gnt cycles 5-8, b_gnt cycle 9.
REQ-040 A writes 0xDEADBEEF to 0x010, next cycle B reads 0x010 -> b_rvalid=1, b_rdata=0xDEADBEEF one cycle after b_gnt.
REQ-041 A read with a_lock=1, B requesting continuously for 10 cycles -> locked=1, b_gnt=0 throughout; A read with a_lock=0 -> locked=0, b_gnt next cycle because starve is saturated.
REQ-042 Alternating A read 0x001, B read 0x002 each cycle -> rvalid alternates A/B with correct data, no bubbles.
REQ-043 rst asserted the cycle after an A read grant -> a_rvalid=0, locked=0, starve=0, ram strobes 0.
REQ-044 Only B requests -> b_gnt same cycle, starve stays 0, ram_address = {20'b0, b_addr}.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port 32-bit word RAM with one-cycle read latency.
// Requester A has default priority. A starved B is promoted, and A can lock B out.
module ram_arbiter #(
  parameter int    UUID         = 0,
  parameter string NAME         = "",
  parameter int    WORD_COUNT   = 4096,
  parameter int    STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic        a_lock,
  input  logic [11:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [11:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        ram_load,
  output logic        ram_save,
  output logic [31:0] ram_address,
  output logic [31:0] ram_in,
  input  logic [31:0] ram_out,
  output logic        locked
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || WORD_COUNT < 1 || WORD_COUNT > 4096) begin : g_bad_params
    $error("ram_arbiter %s (uuid %0d): parameter out of range", NAME, UUID);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  starve_r;
  logic [3:0]  starve_s;
  logic        locked_r;
  logic        locked_s;
  logic        b_pri_s;
  logic        a_gnt_s;
  logic        b_gnt_s;
  logic [11:0] addr_s;

  // Grant decision: B wins only when promoted by starvation or when A is idle, never while locked.
  always_comb begin
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    b_pri_s = (starve_r >= STARVE_MAX) && !locked_r;
    if (rst) begin
      a_gnt_s = 1'b0;
      b_gnt_s = 1'b0;
    end else if (b_req && !locked_r && (b_pri_s || !a_req)) begin
      b_gnt_s = 1'b1;
    end else if (a_req) begin
      a_gnt_s = 1'b1;
    end else begin
      a_gnt_s = 1'b0;
    end
  end

  // RAM port mux: the granted requester owns the RAM for this cycle.
  always_comb begin
    ram_load = 1'b0;
    ram_save = 1'b0;
    addr_s   = 12'd0;
    ram_in   = 32'd0;
    if (a_gnt_s) begin
      ram_load = !a_we;
      ram_save = a_we;
      addr_s   = a_addr;
      ram_in   = a_wdata;
    end else if (b_gnt_s) begin
      ram_load = !b_we;
      ram_save = b_we;
      addr_s   = b_addr;
      ram_in   = b_wdata;
    end else begin
      addr_s   = 12'd0;
    end
    ram_address = {20'd0, addr_s};
    a_gnt       = a_gnt_s;
    b_gnt       = b_gnt_s;
  end

  // Next state: outstanding-read tracking, starvation count and lock status.
  always_comb begin
    state_s  = IDLE;
    starve_s = 4'd0;
    locked_s = locked_r;
    if (a_gnt_s && !a_we) begin
      state_s = RD_A;
    end else if (b_gnt_s && !b_we) begin
      state_s = RD_B;
    end else begin
      state_s = IDLE;
    end
    if (b_req && !b_gnt_s) begin
      starve_s = (starve_r >= STARVE_MAX) ? starve_r : starve_r + 4'd1;
    end else begin
      starve_s = 4'd0;
    end
    if (a_gnt_s) begin
      locked_s = a_lock;
    end else begin
      locked_s = locked_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      starve_r <= 4'd0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      starve_r <= starve_s;
      locked_r <= locked_s;
    end
  end

  // Read response steering; a read pending across reset is dropped.
  always_comb begin
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;
    a_rdata  = 32'd0;
    b_rdata  = 32'd0;
    locked   = locked_r;
    case (state_r)
      RD_A: begin
        a_rvalid = !rst;
        a_rdata  = rst ? 32'd0 : ram_out;
      end
      RD_B: begin
        b_rvalid = !rst;
        b_rdata  = rst ? 32'd0 : ram_out;
      end
      default: begin
        a_rvalid = 1'b0;
        b_rvalid = 1'b0;
      end
    endcase
  end

endmodule
